// File: rtl/mux_pkg.sv
// Shared types and sizes for the round-robin mux select generator.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
// Contents: NUM_SRC, SEL_W, FSM state encoding, beat counter width helper.
package mux_pkg;

  localparam int NUM_SRC = 4;
  localparam int SEL_W   = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GRANT   = 2'b01,
    RELEASE = 2'b10
  } state_t;

  // Beat counter width: max(1, clog2(hold_max)).
  function automatic int cnt_w(input int hold_max);
    return (hold_max > 2) ? $clog2(hold_max) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority picker: first set request searching ptr, ptr+1, .. (mod NUM_SRC).
// Latency: combinational.
// Backpressure: none; pure function of req and ptr.
// Ports: req[3:0] requests, ptr[1:0] search start, idx[1:0] winner, any = some request set.
module rr_pick
  import mux_pkg::*;
(
  input  logic [NUM_SRC-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic [SEL_W-1:0]   idx,
  output logic               any
);

  logic [SEL_W-1:0] cand;

  // Walk from the farthest candidate back to ptr so the closest set bit wins last.
  always_comb begin
    idx  = ptr;
    cand = ptr;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      cand = ptr + SEL_W'(k);
      if (req[cand]) begin
        idx = cand;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/mux_rr_sel_gen.sv
// Round-robin select generator driving the 2-bit sel of a 4:1 mux; holds a grant for up to HOLD_MAX beats.
// Latency: req sampled at one edge -> sel/gnt/sel_valid valid after the next edge; 2 invalid cycles between grants.
// Backpressure: out_ready=0 freezes the beat count and holds the grant; sel only moves while sel_valid=0.
// Ports: clk, rst_n (async, active low), req[3:0], out_ready -> sel[1:0], gnt[3:0], sel_valid.
// Optional: `define MUX_SEL_SCAN_EN adds scan_en/scan_in/scan_out; chain is
//   scan_in -> state[1:0] -> ptr[1:0] -> sel[1:0] -> beat_cnt -> scan_out (MSB first per field).
module mux_rr_sel_gen
  import mux_pkg::*;
#(
  parameter int HOLD_MAX = 4
)
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] req,
  input  logic               out_ready,
`ifdef MUX_SEL_SCAN_EN
  input  logic               scan_en,
  input  logic               scan_in,
  output logic               scan_out,
`endif
  output logic [SEL_W-1:0]   sel,
  output logic [NUM_SRC-1:0] gnt,
  output logic               sel_valid
);

  localparam int               CNT_W    = cnt_w(HOLD_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] pick_idx;
  logic             pick_any;
  logic             grant_end;

`ifdef MUX_SEL_SCAN_EN
  localparam int CHAIN_W = 3 * SEL_W + CNT_W;
  logic [CHAIN_W-1:0] chain_q;
  logic [CHAIN_W-1:0] chain_sh;
`endif

  rr_pick u_pick (
    .req (req),
    .ptr (ptr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    grant_end = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          sel_d   = pick_idx;
          state_d = GRANT;
        end
      end

      GRANT: begin
        // A dropped request wins over a beat in the same cycle: that beat is not counted.
        if (!req[sel_q]) begin
          grant_end = 1'b1;
        end else if (out_ready) begin
          if (cnt_q == CNT_LAST) begin
            grant_end = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        if (grant_end) begin
          state_d = RELEASE;
          ptr_d   = sel_q + 1'b1;
          cnt_d   = '0;
        end
      end

      // One-cycle bubble; sel is left untouched so the mux never sees a mid-switch value.
      RELEASE: state_d = IDLE;

      default: state_d = IDLE;
    endcase

`ifdef MUX_SEL_SCAN_EN
    chain_q  = {state_q, ptr_q, sel_q, cnt_q};
    chain_sh = {scan_in, chain_q[CHAIN_W-1:1]};
    if (scan_en) begin
      state_d = state_t'(chain_sh[CHAIN_W-1 -: SEL_W]);
      ptr_d   = chain_sh[CHAIN_W-SEL_W-1 -: SEL_W];
      sel_d   = chain_sh[CHAIN_W-2*SEL_W-1 -: SEL_W];
      cnt_d   = chain_sh[CNT_W-1:0];
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef MUX_SEL_SCAN_EN
  assign scan_out = cnt_q[0];
`endif

  assign sel       = sel_q;
  assign sel_valid = (state_q == GRANT);

  always_comb begin
    gnt = '0;
    if (sel_valid) begin
      gnt[sel_q] = 1'b1;
    end
  end

endmodule

// File: tb/tb_mux_rr_sel_gen.sv
// Bench for mux_rr_sel_gen: directed scenarios plus randomized req/out_ready against a behavioural model.
// Latency: n/a.
// Backpressure: n/a.
module tb_mux_rr_sel_gen;

  localparam int HOLD_MAX = 4;
  localparam int CNT_W    = 2;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       out_ready;
  logic [1:0] sel;
  logic [3:0] gnt;
  logic       sel_valid;
`ifdef MUX_SEL_SCAN_EN
  logic       scan_en;
  logic       scan_in;
  logic       scan_out;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: who owns the mux, beats taken, bubble pending, rotation start.
  int m_owner;
  int m_sel;
  int m_ptr;
  int m_beats;
  bit m_bubble;

  // Last values sampled from the DUT by step().
  logic [1:0] s_sel;
  logic [3:0] s_gnt;
  logic       s_vld;

  mux_rr_sel_gen #(.HOLD_MAX(HOLD_MAX)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .out_ready (out_ready),
`ifdef MUX_SEL_SCAN_EN
    .scan_en   (scan_en),
    .scan_in   (scan_in),
    .scan_out  (scan_out),
`endif
    .sel       (sel),
    .gnt       (gnt),
    .sel_valid (sel_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner  = -1;
    m_sel    = 0;
    m_ptr    = 0;
    m_beats  = 0;
    m_bubble = 1'b0;
  endtask

  // Advance the model by one clock given the inputs held over that clock.
  task automatic model_step(input logic [3:0] r, input logic rdy);
    bit end_grant;
    int s;
    end_grant = 1'b0;
    if (m_owner >= 0) begin
      if (r[m_owner] == 1'b0) begin
        end_grant = 1'b1;
      end else if (rdy) begin
        m_beats++;
        if (m_beats >= HOLD_MAX) end_grant = 1'b1;
      end
      if (end_grant) begin
        m_ptr    = (m_owner + 1) % 4;
        m_owner  = -1;
        m_bubble = 1'b1;
        m_beats  = 0;
      end
    end else if (m_bubble) begin
      m_bubble = 1'b0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        s = (m_ptr + k) % 4;
        if (r[s]) begin
          m_owner = s;
          m_sel   = s;
          break;
        end
      end
    end
  endtask

  // Sample and check outputs at the falling edge, then apply inputs for the next rising edge.
  task automatic step(input logic [3:0] r, input logic rdy);
    logic [3:0] exp_gnt;
    @(negedge clk);
    s_sel = sel;
    s_gnt = gnt;
    s_vld = sel_valid;
    exp_gnt = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    check("model_vld", s_vld, (m_owner >= 0) ? 1 : 0);
    check("model_sel", s_sel, m_sel);
    check("model_gnt", s_gnt, exp_gnt);
    req       = r;
    out_ready = rdy;
    model_step(r, rdy);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    req       = 4'b0000;
    out_ready = 1'b0;
    #1;
    check("rst_sel", sel, 0);
    check("rst_gnt", gnt, 0);
    check("rst_vld", sel_valid, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] rr;
    logic       rd;
    int         exp_v;
    int         exp_s;
    int         j;

    rst_n     = 1'b0;
    req       = 4'b0000;
    out_ready = 1'b0;
`ifdef MUX_SEL_SCAN_EN
    scan_en   = 1'b0;
    scan_in   = 1'b0;
`endif
    model_reset();

    // Single requester: grant visible one clock after req is sampled.
    do_reset();
    step(4'b0001, 1'b1);
    step(4'b0001, 1'b1);
    check("first_sel", s_sel, 0);
    check("first_gnt", s_gnt, 4'b0001);
    check("first_vld", s_vld, 1);

    // All requesting: 0,1,2,3,0 each for 4 valid cycles with 2 invalid cycles between.
    do_reset();
    for (int i = 0; i < 31; i++) begin
      step(4'b1111, 1'b1);
      if (i == 0) begin
        exp_v = 0;
        exp_s = 0;
      end else begin
        j     = (i - 1) % 6;
        exp_v = (j < 4) ? 1 : 0;
        exp_s = ((i - 1) / 6) % 4;
      end
      check("rr_vld", s_vld, exp_v);
      if (exp_v == 1) check("rr_sel", s_sel, exp_s);
    end

    // Grant on 3 ends; next arbitration with req=1001 wraps to source 0.
    do_reset();
    for (int i = 0; i < 5; i++) step(4'b1000, 1'b1);
    check("wrap_own3", s_sel, 3);
    step(4'b1001, 1'b1);
    check("wrap_bubble1", s_vld, 0);
    step(4'b1001, 1'b1);
    check("wrap_bubble2", s_vld, 0);
    step(4'b1001, 1'b1);
    check("wrap_sel", s_sel, 0);
    check("wrap_gnt", s_gnt, 4'b0001);

    // Stall on source 2, then drop its request.
    do_reset();
    step(4'b0100, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(4'b0100, 1'b0);
      check("stall_sel", s_sel, 2);
      check("stall_vld", s_vld, 1);
    end
    step(4'b0000, 1'b1);
    check("drop_still_vld", s_vld, 1);
    step(4'b0000, 1'b1);
    check("drop_vld", s_vld, 0);
    check("drop_sel_held", s_sel, 2);

    // Asynchronous reset in the middle of a grant on source 1.
    do_reset();
    step(4'b0010, 1'b1);
    step(4'b0010, 1'b1);
    check("mid_pre_sel", s_sel, 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_sel", sel, 0);
    check("async_gnt", gnt, 0);
    check("async_vld", sel_valid, 0);
    req = 4'b0000;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rr = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 4) == 0) rr = 4'b0000;
      rd = ($urandom_range(0, 3) != 0);
      step(rr, rd);
    end

`ifdef MUX_SEL_SCAN_EN
    begin
      localparam int CHAIN_N = 6 + CNT_W;
      logic [CHAIN_N-1:0] pat;
      pat = CHAIN_N'($urandom);
      for (int i = 0; i < 2 * CHAIN_N; i++) begin
        @(negedge clk);
        scan_en = 1'b1;
        if (i >= CHAIN_N) check("scan_out", scan_out, pat[i-CHAIN_N]);
        scan_in = (i < CHAIN_N) ? pat[i] : 1'b0;
      end
      @(negedge clk);
      scan_en = 1'b0;
      do_reset();
      for (int i = 0; i < 40; i++) step(4'($urandom_range(0, 15)), 1'b1);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
